// File: rtl/core_mem_seq.sv
// core_mem_seq: registered memory sequencer between the core, the internal
// ROM/RAM macros and the external bus controller. It handles one request at
// a time with a req/ack handshake. Bit-addressable RAM writes are done in
// hardware as a read-modify-write.
//
// Optional feature macro: MSEQ_EXT_RDY_EN
//   When defined, input mseq_ext_rdy_i is added. After the EXT_WS wait
//   states the external strobe is held low until rdy = 1 is sampled.
//
// Ports:
//   mseq_clk_i / mseq_rst_b_i    clock (rising edge), async active-low reset
//   mseq_req_i                   request strobe, sampled only in IDLE
//   mseq_cmd_i                   00 ROM rd, 01 RAM rd, 10 RAM wr, 11 reserved
//   mseq_bit_i, mseq_ext_ram_i   RAM bit access / RAM access goes external
//   mseq_ea_b_i                  external-access pin (latched after reset)
//   mseq_addr_i, mseq_wdata_i    request address / write data
//   mseq_ack_o, mseq_rdata_o     completion pulse / read data (held)
//   mseq_busy_o                  FSM not in IDLE
//   mseq_rom_*                   internal ROM macro interface
//   mseq_ram_*                   internal RAM macro interface
//   mseq_ext_*                   external bus address, data and strobes
//
// States:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for a request
//   S_INT    | internal enable cycle (ROM/RAM read, byte write, RMW write)
//   S_EXT    | external access: setup cycle, then strobe low for the wait count
//   S_RMW_RD | bit write: internal byte read enable cycle
//   S_RMW_WR | bit write: read byte is on Q; merge the new bit, schedule the write
//   S_DONE   | capture internal read data, pulse ack
module core_mem_seq #(
  parameter int         ROM_AW   = 12,
  parameter int         RAM_AW   = 7,
  parameter logic [7:0] BIT_BASE = 8'h20,
  parameter int         EXT_WS   = 2
) (
  input  logic              mseq_clk_i,
  input  logic              mseq_rst_b_i,
  input  logic              mseq_req_i,
  input  logic [1:0]        mseq_cmd_i,
  input  logic              mseq_bit_i,
  input  logic              mseq_ext_ram_i,
  input  logic              mseq_ea_b_i,
  input  logic [15:0]       mseq_addr_i,
  input  logic [7:0]        mseq_wdata_i,
  output logic              mseq_ack_o,
  output logic [7:0]        mseq_rdata_o,
  output logic              mseq_busy_o,
  output logic              mseq_rom_en_b_o,
  output logic [ROM_AW-1:0] mseq_rom_addr_o,
  input  logic [7:0]        mseq_rom_data_i,
  output logic              mseq_ram_en_b_o,
  output logic              mseq_ram_wr_b_o,
  output logic [RAM_AW-1:0] mseq_ram_addr_o,
  output logic [7:0]        mseq_ram_data_o,
  input  logic [7:0]        mseq_ram_data_i,
  output logic [15:0]       mseq_ext_addr_o,
  output logic [7:0]        mseq_ext_data_o,
  input  logic [7:0]        mseq_ext_data_i,
`ifdef MSEQ_EXT_RDY_EN
  input  logic              mseq_ext_rdy_i,
`endif
  output logic              mseq_ext_rom_rd_b_o,
  output logic              mseq_ext_ram_rd_b_o,
  output logic              mseq_ext_ram_wr_b_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_INT, S_EXT, S_RMW_RD, S_RMW_WR, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        op_q, op_d;
  logic              bit_q, bit_d;
  logic [2:0]        idx_q, idx_d;
  logic              wbit_q, wbit_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ea_lat_q, ea_done_q;

  logic              rom_en_b_q, rom_en_b_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              ram_en_b_q, ram_en_b_d;
  logic              ram_wr_b_q, ram_wr_b_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic [15:0]       ext_addr_q, ext_addr_d;
  logic [7:0]        ext_data_q, ext_data_d;
  logic              ext_rom_rd_b_q, ext_rom_rd_b_d;
  logic              ext_ram_rd_b_q, ext_ram_rd_b_d;
  logic              ext_ram_wr_b_q, ext_ram_wr_b_d;
  logic              ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              busy_q, busy_d;

  logic              ea_eff;
  logic              rom_ext;
  logic              ext_rdy;
  logic              strobe_on;
  logic [7:0]        merged;

`ifdef MSEQ_EXT_RDY_EN
  assign ext_rdy = mseq_ext_rdy_i;
`else
  assign ext_rdy = 1'b1;
`endif

  // A request on the very first edge after reset release must already see
  // the pin value that is being latched on that edge.
  assign ea_eff    = ea_done_q ? ea_lat_q : mseq_ea_b_i;
  assign rom_ext   = ~ea_eff | ((mseq_addr_i >> ROM_AW) != 16'd0);
  assign strobe_on = ~(ext_rom_rd_b_q & ext_ram_rd_b_q & ext_ram_wr_b_q);

  always_ff @(posedge mseq_clk_i or negedge mseq_rst_b_i) begin
    if (!mseq_rst_b_i) begin
      ea_lat_q  <= 1'b1;
      ea_done_q <= 1'b0;
    end else if (!ea_done_q) begin
      ea_lat_q  <= mseq_ea_b_i;
      ea_done_q <= 1'b1;
    end
  end

  always_ff @(posedge mseq_clk_i or negedge mseq_rst_b_i) begin
    if (!mseq_rst_b_i) begin
      state_q        <= S_IDLE;
      op_q           <= 2'b00;
      bit_q          <= 1'b0;
      idx_q          <= 3'd0;
      wbit_q         <= 1'b0;
      cnt_q          <= 3'd0;
      rom_en_b_q     <= 1'b1;
      rom_addr_q     <= '0;
      ram_en_b_q     <= 1'b1;
      ram_wr_b_q     <= 1'b1;
      ram_addr_q     <= '0;
      ram_data_q     <= 8'h00;
      ext_addr_q     <= 16'h0000;
      ext_data_q     <= 8'h00;
      ext_rom_rd_b_q <= 1'b1;
      ext_ram_rd_b_q <= 1'b1;
      ext_ram_wr_b_q <= 1'b1;
      ack_q          <= 1'b0;
      rdata_q        <= 8'h00;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      bit_q          <= bit_d;
      idx_q          <= idx_d;
      wbit_q         <= wbit_d;
      cnt_q          <= cnt_d;
      rom_en_b_q     <= rom_en_b_d;
      rom_addr_q     <= rom_addr_d;
      ram_en_b_q     <= ram_en_b_d;
      ram_wr_b_q     <= ram_wr_b_d;
      ram_addr_q     <= ram_addr_d;
      ram_data_q     <= ram_data_d;
      ext_addr_q     <= ext_addr_d;
      ext_data_q     <= ext_data_d;
      ext_rom_rd_b_q <= ext_rom_rd_b_d;
      ext_ram_rd_b_q <= ext_ram_rd_b_d;
      ext_ram_wr_b_q <= ext_ram_wr_b_d;
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    bit_d          = bit_q;
    idx_d          = idx_q;
    wbit_d         = wbit_q;
    cnt_d          = cnt_q;
    rom_en_b_d     = 1'b1;
    rom_addr_d     = rom_addr_q;
    ram_en_b_d     = 1'b1;
    ram_wr_b_d     = 1'b1;
    ram_addr_d     = ram_addr_q;
    ram_data_d     = ram_data_q;
    ext_addr_d     = ext_addr_q;
    ext_data_d     = ext_data_q;
    ext_rom_rd_b_d = 1'b1;
    ext_ram_rd_b_d = 1'b1;
    ext_ram_wr_b_d = 1'b1;
    ack_d          = 1'b0;
    rdata_d        = rdata_q;
    merged         = mseq_ram_data_i;
    merged[idx_q]  = wbit_q;

    case (state_q)
      S_IDLE: begin
        if (mseq_req_i) begin
          op_d   = mseq_cmd_i;
          bit_d  = mseq_bit_i & ~mseq_ext_ram_i;
          idx_d  = mseq_addr_i[2:0];
          wbit_d = mseq_wdata_i[0];
          case (mseq_cmd_i)
            2'b00: begin
              if (rom_ext) begin
                ext_addr_d = mseq_addr_i;
                state_d    = S_EXT;
              end else begin
                rom_en_b_d = 1'b0;
                rom_addr_d = mseq_addr_i[ROM_AW-1:0];
                state_d    = S_INT;
              end
            end
            2'b01, 2'b10: begin
              if (mseq_ext_ram_i) begin
                ext_addr_d = {8'h00, mseq_addr_i[7:0]};
                if (mseq_cmd_i == 2'b10) ext_data_d = mseq_wdata_i;
                state_d = S_EXT;
              end else begin
                ram_en_b_d = 1'b0;
                if (mseq_bit_i)
                  ram_addr_d = RAM_AW'(BIT_BASE + {4'b0000, mseq_addr_i[6:3]});
                else
                  ram_addr_d = mseq_addr_i[RAM_AW-1:0];
                if (mseq_cmd_i == 2'b10 && mseq_bit_i) begin
                  state_d = S_RMW_RD;
                end else begin
                  if (mseq_cmd_i == 2'b10) begin
                    ram_wr_b_d = 1'b0;
                    ram_data_d = mseq_wdata_i;
                  end
                  state_d = S_INT;
                end
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end

      S_INT:    state_d = S_DONE;
      S_RMW_RD: state_d = S_RMW_WR;

      S_RMW_WR: begin
        ram_en_b_d = 1'b0;
        ram_wr_b_d = 1'b0;
        ram_data_d = merged;
        state_d    = S_INT;
      end

      S_DONE: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
        // Only internal reads arrive here with data to return; writes and
        // the reserved command leave rdata untouched.
        if (op_q == 2'b00)
          rdata_d = mseq_rom_data_i;
        else if (op_q == 2'b01)
          rdata_d = bit_q ? {7'b0000000, mseq_ram_data_i[idx_q]} : mseq_ram_data_i;
      end

      S_EXT: begin
        if (strobe_on && cnt_q == 3'd0 && ext_rdy) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
          if (op_q != 2'b10) rdata_d = mseq_ext_data_i;
        end else begin
          if (!strobe_on)
            cnt_d = 3'(EXT_WS);
          else if (cnt_q != 3'd0)
            cnt_d = cnt_q - 3'd1;
          case (op_q)
            2'b00:   ext_rom_rd_b_d = 1'b0;
            2'b01:   ext_ram_rd_b_d = 1'b0;
            2'b10:   ext_ram_wr_b_d = 1'b0;
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign mseq_ack_o          = ack_q;
  assign mseq_rdata_o        = rdata_q;
  assign mseq_busy_o         = busy_q;
  assign mseq_rom_en_b_o     = rom_en_b_q;
  assign mseq_rom_addr_o     = rom_addr_q;
  assign mseq_ram_en_b_o     = ram_en_b_q;
  assign mseq_ram_wr_b_o     = ram_wr_b_q;
  assign mseq_ram_addr_o     = ram_addr_q;
  assign mseq_ram_data_o     = ram_data_q;
  assign mseq_ext_addr_o     = ext_addr_q;
  assign mseq_ext_data_o     = ext_data_q;
  assign mseq_ext_rom_rd_b_o = ext_rom_rd_b_q;
  assign mseq_ext_ram_rd_b_o = ext_ram_rd_b_q;
  assign mseq_ext_ram_wr_b_o = ext_ram_wr_b_q;

endmodule

// File: tb/tb_core_mem_seq.sv
// Testbench for core_mem_seq with default parameters (EXT_WS = 2).
// Synchronous ROM/RAM models respond to the enables; each request is timed
// from its acceptance edge and strobe-low cycles are counted per signal.
`timescale 1ns/1ps
module tb_core_mem_seq;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        mbit = 1'b0;
  logic        ext_ram = 1'b0;
  logic        ea_b = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  ext_din = 8'h00;
`ifdef MSEQ_EXT_RDY_EN
  logic        rdy = 1'b1;
`endif

  logic        ack, busy, rom_en_b, ram_en_b, ram_wr_b;
  logic        xrom_b, xrd_b, xwr_b;
  logic [7:0]  rdata, ram_wdata, ext_data;
  logic [11:0] rom_addr;
  logic [6:0]  ram_addr;
  logic [15:0] ext_addr;
  logic [7:0]  rom_q, ram_q;
  logic [7:0]  ram_mem [128];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_mem_seq dut (
    .mseq_clk_i(clk), .mseq_rst_b_i(rst_b), .mseq_req_i(req),
    .mseq_cmd_i(cmd), .mseq_bit_i(mbit), .mseq_ext_ram_i(ext_ram),
    .mseq_ea_b_i(ea_b), .mseq_addr_i(addr), .mseq_wdata_i(wdata),
    .mseq_ack_o(ack), .mseq_rdata_o(rdata), .mseq_busy_o(busy),
    .mseq_rom_en_b_o(rom_en_b), .mseq_rom_addr_o(rom_addr), .mseq_rom_data_i(rom_q),
    .mseq_ram_en_b_o(ram_en_b), .mseq_ram_wr_b_o(ram_wr_b), .mseq_ram_addr_o(ram_addr),
    .mseq_ram_data_o(ram_wdata), .mseq_ram_data_i(ram_q),
    .mseq_ext_addr_o(ext_addr), .mseq_ext_data_o(ext_data), .mseq_ext_data_i(ext_din),
`ifdef MSEQ_EXT_RDY_EN
    .mseq_ext_rdy_i(rdy),
`endif
    .mseq_ext_rom_rd_b_o(xrom_b), .mseq_ext_ram_rd_b_o(xrd_b), .mseq_ext_ram_wr_b_o(xwr_b)
  );

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    return (a == 12'h123) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (!rom_en_b) rom_q <= rom_fn(rom_addr);
    if (!ram_en_b) begin
      if (!ram_wr_b) ram_mem[ram_addr] <= ram_wdata;
      else           ram_q <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request; lat = edges from acceptance to ack (-1 on timeout).
  // cnts = strobe-low cycle counts {rom_en, ram_en, ram_wr, xrom, xrd, xwr}.
  task automatic do_req(input logic [1:0] c, input logic b, input logic e,
                        input logic [15:0] a, input logic [7:0] w, input logic [7:0] xd,
                        output int lat, output logic [7:0] rd, output logic [23:0] cnts,
                        output logic [15:0] xa, output logic [7:0] xdo, output logic [11:0] ra);
    @(negedge clk);
    req = 1'b1; cmd = c; mbit = b; ext_ram = e; addr = a; wdata = w; ext_din = xd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1; rd = 8'h00; cnts = '0; xa = '0; xdo = '0; ra = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) begin xa = ext_addr; xdo = ext_data; ra = rom_addr; end
      if (!rom_en_b) cnts[23:20] = cnts[23:20] + 4'd1;
      if (!ram_en_b) cnts[19:16] = cnts[19:16] + 4'd1;
      if (!ram_wr_b) cnts[15:12] = cnts[15:12] + 4'd1;
      if (!xrom_b)   cnts[11:8]  = cnts[11:8]  + 4'd1;
      if (!xrd_b)    cnts[7:4]   = cnts[7:4]   + 4'd1;
      if (!xwr_b)    cnts[3:0]   = cnts[3:0]   + 4'd1;
      if (ack) begin lat = n; rd = rdata; break; end
    end
  endtask

  typedef struct {
    logic [1:0]  c;   logic b;   logic e;   logic [15:0] a;   logic [7:0] w;  logic [7:0] xd;
    int          lat; logic chk_rd; logic [7:0] rd; logic [23:0] cnts;
    logic chk_ra; logic [11:0] ra; logic chk_xa; logic [15:0] xa; logic chk_xd; logic [7:0] xdo;
  } vec_t;

  vec_t v [18];

  int          lat;
  logic [7:0]  rd, xdo;
  logic [23:0] cnts;
  logic [15:0] xa;
  logic [11:0] ra;
  int          acks;
  logic [9:0]  pat;

  initial begin
    v[0]  = '{2'b00,1'b0,1'b0,16'h0123,8'h00,8'h00, 2,1'b1,8'hA5,24'h100000, 1'b1,12'h123, 1'b0,16'h0000, 1'b0,8'h00};
    v[1]  = '{2'b00,1'b0,1'b0,16'h1000,8'h00,8'h3C, 4,1'b1,8'h3C,24'h000300, 1'b0,12'h000, 1'b1,16'h1000, 1'b0,8'h00};
    v[2]  = '{2'b00,1'b0,1'b0,16'h0FFF,8'h00,8'h00, 2,1'b1,8'hC3,24'h100000, 1'b1,12'hFFF, 1'b0,16'h0000, 1'b0,8'h00};
    v[3]  = '{2'b10,1'b0,1'b0,16'h0022,8'h00,8'h00, 2,1'b0,8'h00,24'h011000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[4]  = '{2'b10,1'b0,1'b0,16'h002F,8'h80,8'h00, 2,1'b0,8'h00,24'h011000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[5]  = '{2'b10,1'b0,1'b0,16'h0020,8'hFE,8'h00, 2,1'b0,8'h00,24'h011000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[6]  = '{2'b10,1'b1,1'b0,16'h0013,8'h01,8'h00, 4,1'b0,8'h00,24'h021000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[7]  = '{2'b01,1'b0,1'b0,16'h0022,8'h00,8'h00, 2,1'b1,8'h08,24'h010000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[8]  = '{2'b01,1'b1,1'b0,16'h0013,8'h00,8'h00, 2,1'b1,8'h01,24'h010000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[9]  = '{2'b10,1'b1,1'b0,16'h0010,8'hFF,8'h00, 4,1'b0,8'h00,24'h021000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[10] = '{2'b10,1'b1,1'b0,16'h0013,8'hFE,8'h00, 4,1'b0,8'h00,24'h021000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[11] = '{2'b01,1'b0,1'b0,16'h0022,8'h00,8'h00, 2,1'b1,8'h01,24'h010000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[12] = '{2'b01,1'b1,1'b0,16'h007F,8'h00,8'h00, 2,1'b1,8'h01,24'h010000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[13] = '{2'b01,1'b1,1'b0,16'h0080,8'h00,8'h00, 2,1'b1,8'h00,24'h010000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[14] = '{2'b10,1'b1,1'b1,16'hAB45,8'h77,8'h00, 4,1'b0,8'h00,24'h000003, 1'b0,12'h000, 1'b1,16'h0045, 1'b1,8'h77};
    v[15] = '{2'b01,1'b1,1'b1,16'h0045,8'h00,8'h5E, 4,1'b1,8'h5E,24'h000030, 1'b0,12'h000, 1'b1,16'h0045, 1'b0,8'h00};
    v[16] = '{2'b11,1'b0,1'b0,16'h0123,8'h00,8'h00, 1,1'b1,8'h5E,24'h000000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};
    v[17] = '{2'b01,1'b0,1'b0,16'h002F,8'h00,8'h00, 2,1'b1,8'h80,24'h010000, 1'b0,12'h000, 1'b0,16'h0000, 1'b0,8'h00};

    // Reset values
    #23;
    chk("rst_ctrl", {rom_en_b, ram_en_b, ram_wr_b, xrom_b, xrd_b, xwr_b, ack, busy}, 8'b1111_1100);
    chk("rst_data", {rom_addr, ram_addr, ram_wdata, ext_addr, ext_data, rdata}, 64'h0);
    @(negedge clk); rst_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      do_req(v[i].c, v[i].b, v[i].e, v[i].a, v[i].w, v[i].xd, lat, rd, cnts, xa, xdo, ra);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(v[i].lat));
      chk($sformatf("v%0d_strobes", i), 64'(cnts), 64'(v[i].cnts));
      if (v[i].chk_rd) chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(v[i].rd));
      if (v[i].chk_ra) chk($sformatf("v%0d_rom_addr", i), 64'(ra), 64'(v[i].ra));
      if (v[i].chk_xa) chk($sformatf("v%0d_ext_addr", i), 64'(xa), 64'(v[i].xa));
      if (v[i].chk_xd) chk($sformatf("v%0d_ext_data", i), 64'(xdo), 64'(v[i].xdo));
    end

    // ea_b = 0 at reset release: low ROM address goes external, and the
    // latch stays frozen after the pin returns high.
    @(negedge clk); rst_b = 1'b0; ea_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1 ea_b = 1'b1;
    do_req(2'b00, 1'b0, 1'b0, 16'h0010, 8'h00, 8'h96, lat, rd, cnts, xa, xdo, ra);
    chk("ea0_lat", 64'(lat), 64'd4);
    chk("ea0_strobes", 64'(cnts), 64'h000300);
    chk("ea0_ext_addr", 64'(xa), 64'h0010);
    chk("ea0_rdata", 64'(rd), 64'h96);

    // Reset in the middle of an external write strobe
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk);
    req = 1'b1; cmd = 2'b10; mbit = 1'b0; ext_ram = 1'b1; addr = 16'h0045; wdata = 8'h11;
    @(posedge clk); #1 req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_strobe_low", 64'(xwr_b), 64'd0);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_outputs", {xrom_b, xrd_b, xwr_b, busy, ack}, 5'b11100);
    acks = 0;
    repeat (3) begin @(negedge clk); if (ack) acks++; end
    rst_b = 1'b1;
    repeat (4) begin @(negedge clk); if (ack) acks++; end
    chk("mid_rst_no_ack", 64'(acks), 64'd0);
    do_req(2'b00, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h00, lat, rd, cnts, xa, xdo, ra);
    chk("post_rst_lat", 64'(lat), 64'd2);
    chk("post_rst_rdata", 64'(rd), 64'hA5);

    // Requests while busy are dropped
    @(negedge clk);
    req = 1'b1; cmd = 2'b00; mbit = 1'b0; ext_ram = 1'b0; addr = 16'h1000; ext_din = 8'h3C;
    @(posedge clk); #1 req = 1'b0;
    acks = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ack) acks++;
      req = (n == 0 || n == 1 || n == 3);
    end
    req = 1'b0;
    chk("busy_ignore_acks", 64'(acks), 64'd1);

    // Req held high: reserved command re-accepted every other edge
    @(negedge clk);
    req = 1'b1; cmd = 2'b11;
    @(posedge clk);
    pat = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      pat[n] = ack;
    end
    req = 1'b0;
    chk("b2b_ack_pattern", 64'(pat), 64'b1010101010);
    repeat (3) @(negedge clk);

`ifdef MSEQ_EXT_RDY_EN
    // rdy held low extends the strobe; completion on the edge rdy is seen
    @(negedge clk);
    rdy = 1'b0;
    req = 1'b1; cmd = 2'b00; addr = 16'h2000; ext_din = 8'h4B;
    @(posedge clk); #1 req = 1'b0;
    lat = -1; rd = 8'h00; cnts = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!xrom_b) cnts = cnts + 24'd1;
      if (ack) begin lat = n; rd = rdata; break; end
      if (n == 5) rdy = 1'b1;
    end
    rdy = 1'b1;
    chk("rdy_lat", 64'(lat), 64'd6);
    chk("rdy_strobe_cycles", 64'(cnts), 64'd5);
    chk("rdy_rdata", 64'(rd), 64'h4B);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_mem_seq.md
Name: core_mem_seq

Overview:
- Parametrised, registered successor of the core memory controller; sits between the core and the internal ROM/RAM macros plus the external bus controller.
- Handles one request at a time via req/ack; internal/external steering; programmable external wait states; bit-addressable RAM with hardware read-modify-write.

Parameters:
ROM_AW, 12, internal ROM address width; addresses above 2**ROM_AW-1 are external
RAM_AW, 7, internal RAM address width
BIT_BASE, 8'h20, first internal RAM byte of the bit-addressable area
EXT_WS, 2, external wait states (strobe low for EXT_WS+1 cycles), 0..7

Ports:
mseq_clk_i  in  1  clock, rising edge
mseq_rst_b_i  in  1  asynchronous reset, active low
mseq_req_i  in  1  request strobe; sampled only in IDLE
mseq_cmd_i  in  2  00 ROM read, 01 RAM read, 10 RAM write, 11 reserved (acked, no access)
mseq_bit_i  in  1  RAM access is a bit access
mseq_ext_ram_i  in  1  RAM access goes to the external bus
mseq_ea_b_i  in  1  external-access pin; 0 = all ROM reads external
mseq_addr_i  in  16  ROM address, or RAM byte/bit address in [7:0]
mseq_wdata_i  in  8  write data; bit write uses [0]
mseq_ack_o  out  1  one-cycle completion pulse
mseq_rdata_o  out  8  read data, valid with ack and held until next ack
mseq_busy_o  out  1  high whenever the FSM is not in IDLE
mseq_rom_en_b_o  out  1  internal ROM enable
mseq_rom_addr_o  out  ROM_AW  internal ROM address
mseq_rom_data_i  in  8  internal ROM Q
mseq_ram_en_b_o  out  1  internal RAM enable
mseq_ram_wr_b_o  out  1  internal RAM write enable
mseq_ram_addr_o  out  RAM_AW  internal RAM address
mseq_ram_data_o  out  8  internal RAM D
mseq_ram_data_i  in  8  internal RAM Q
mseq_ext_addr_o  out  16  external address
mseq_ext_data_o  out  8  external write data
mseq_ext_data_i  in  8  external read data
mseq_ext_rom_rd_b_o  out  1  external ROM read strobe
mseq_ext_ram_rd_b_o  out  1  external RAM read strobe
mseq_ext_ram_wr_b_o  out  1  external RAM write strobe

Behaviour:
- Reset: all *_b outputs 1; addresses, data, rdata 0; ack 0; busy 0; FSM IDLE; ea latch 1. Mid-operation reset drops strobes immediately and abandons the access with no ack.
- ea latch: mseq_ea_b_i captured on the first clock edge after reset release, then frozen.
- Steering: ROM read is external when ea latch = 0 or addr > 2**ROM_AW-1. RAM access is external when ext_ram_i = 1; external RAM uses address {8'h00, addr[7:0]} and ignores bit_i.
- FSM states: IDLE, INT, EXT, RMW_RD, RMW_WR, DONE. All outputs registered.
- Request accepted at edge k in IDLE; req while busy is ignored (not queued). Command, address and data are captured at acceptance.
- Internal byte read/write, and internal bit read: enables asserted during cycle k..k+1; memory clocks at k+1; ack high during cycle after k+2.
- Bit address: byte = BIT_BASE + addr[6:3]; bit index = addr[2:0].
- Bit read returns {7'b0, Q[idx]}.
- Bit write: RMW_RD reads the byte; RMW_WR writes it with bit idx replaced by wdata[0], all other bits preserved; ack after edge k+4.
- External: strobe low for EXT_WS+1 cycles; read data captured on the last strobe edge; ack after edge k+EXT_WS+2. Address and data are stable one cycle before and through the strobe.
- cmd 11: ack after k+1, rdata unchanged.
- Back-to-back: req held high is re-accepted on the edge after DONE.

Optional Feature:
MSEQ_EXT_RDY_EN
- Defined: adds input mseq_ext_rdy_i. After EXT_WS cycles the strobe stays low until rdy = 1 is sampled; the access then completes as normal. No timeout.
- Undefined: port absent; fixed EXT_WS timing.

Test Plan:
- Reset with ea_b = 1, ROM read addr 16'h0123, ROM Q = 8'hA5 -> rom_en_b low cycles k..k+1, rom_addr 12'h123, rdata 8'hA5 with ack at k+2, no external strobe.
- ROM read addr 16'h1000, EXT_WS = 2, ext_data_i = 8'h3C -> ext_rom_rd_b low 3 cycles, ext_addr 16'h1000, ack at k+4, rdata 8'h3C. Repeat with ea_b = 0 at reset and addr 16'h0010 -> external.
- Internal RAM 8'h22 = 8'h00; bit write addr 8'h13 (byte 8'h22, bit 3), wdata 1 -> byte becomes 8'h08, ack at k+4; bit read same address -> rdata 8'h01.
- External RAM write addr 8'h45, data 8'h77 -> ext_addr 16'h0045, ext_data 8'h77, ext_ram_wr_b low EXT_WS+1 cycles, internal RAM enables stay high.
- Reset asserted during EXT cycle 2 -> all strobes 1 asynchronously, no ack; next request after release is serviced normally.
- req pulses while busy are ignored, exactly one ack per accepted request; MSEQ_EXT_RDY_EN build with rdy low 5 cycles -> strobe extended, ack 1 cycle after rdy is sampled high.
